// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order WB has priority, out-of-order
// long-latency results are buffered and force a one-cycle WB stall when starved.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ws_reg_wen,
  input  logic [4:0]              ws_rd,
  input  logic [31:0]             ws_reg_wdata,
  output logic                    wb_stall,
  input  logic                    lu_valid,
  input  logic [4:0]              lu_rd,
  input  logic [31:0]             lu_wdata,
  output logic                    lu_ready,
  output logic                    rf_wen,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [31:0]             pend_rd_mask,
  output logic [$clog2(DEPTH):0]  lu_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;

  logic          wb_req;
  logic          has;
  logic          stall;
  logic          ready;
  logic          accept;
  logic          pop;
  logic          push;
  logic          bypass;
  logic [AW-1:0] off;
  logic [31:0]   mask;

  always_comb begin
    wb_req = rst_n && ws_reg_wen && (ws_rd != 5'd0);
    has    = count != '0;
    stall  = rst_n && has && (starve == SMAX);
    ready  = rst_n && (count < FULL);
    accept = lu_valid && ready;
    pop    = stall || (rst_n && has && !wb_req);
    bypass = accept && !has && !wb_req && (lu_rd != 5'd0);
    push   = accept && (lu_rd != 5'd0) && !bypass;
  end

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pop) begin
      rf_wen   = 1'b1;
      rf_waddr = rd_q[head];
      rf_wdata = data_q[head];
    end else if (wb_req) begin
      rf_wen   = 1'b1;
      rf_waddr = ws_rd;
      rf_wdata = ws_reg_wdata;
    end else if (bypass) begin
      rf_wen   = 1'b1;
      rf_waddr = lu_rd;
      rf_wdata = lu_wdata;
    end
  end

  // Slot i is live when its distance from head is below count.
  always_comb begin
    mask = 32'd0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head;
      if (CW'(off) < count) mask[rd_q[i]] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign wb_stall     = stall;
  assign lu_ready     = ready;
  assign pend_rd_mask = rst_n ? mask : 32'd0;
  assign lu_count     = rst_n ? count : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (pop || !has)        starve <= '0;
      else if (starve != SMAX) starve <= starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= lu_rd;
      data_q[tail] <= lu_wdata;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the register-file write port between the in-order write-back stage and a long-latency completion unit (multiply/divide or similar) that returns results out of pipeline order. WB results have priority. Long-latency results are buffered in a small FIFO, and a starvation counter guarantees they eventually drain by stalling WB for one cycle. The block sits between `wb_stage`/the long-latency unit and the register file. It also exports a pending-destination mask for the decode scoreboard.

## Interface
Parameters:
- `DEPTH`, 2: long-latency FIFO entries; power of two, ≥2.
- `STARVE_MAX`, 4: cycles a buffered entry may wait before WB is stalled; ≥1.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ws_reg_wen` in 1: WB write request.
- `ws_rd` in 5: WB destination register.
- `ws_reg_wdata` in 32: WB write data.
- `wb_stall` out 1: WB must hold its current contents and re-present them next cycle.
- `lu_valid` in 1: long-latency result valid.
- `lu_rd` in 5: long-latency destination register.
- `lu_wdata` in 32: long-latency result data.
- `lu_ready` out 1: arbiter accepts the long-latency result this cycle.
- `rf_wen` out 1: register-file write enable.
- `rf_waddr` out 5: register-file write address.
- `rf_wdata` out 32: register-file write data.
- `pend_rd_mask` out 32: one-hot OR of the rd fields of all buffered entries; bit 0 is always 0.
- `lu_count` out clog2(DEPTH)+1: number of buffered entries.

## Operation
- **State:**
  - FIFO with head/tail pointers and a count.
  - Starvation counter `starve`, width clog2(STARVE_MAX+1).
- **Derived signals:**
  - WB request: `wb_req = ws_reg_wen && ws_rd != 0`. Writes to x0 never drive `rf_wen`.
  - `wb_stall = (starve == STARVE_MAX) && count != 0`. It is a combinational function of registered state only.
  - `lu_ready = (count < DEPTH)`, from registered count. There is no same-cycle push-when-full, even if a pop occurs in that cycle.
- **Port priority each cycle, first match wins:**
  1. `wb_stall`: pop the FIFO head and write it. The WB request is ignored because WB is held.
  2. `wb_req`: write the WB data. The FIFO is not popped.
  3. `count != 0`: pop the head and write it.
  4. `lu_valid && lu_ready && lu_rd != 0`: bypass and write the LU data directly; no push. This applies only when count == 0.
  5. Otherwise `rf_wen = 0`; `rf_waddr`/`rf_wdata` are don't-care and driven as 0.
- **LU handshake:**
  - An accepted LU result (`lu_valid && lu_ready`) with `lu_rd == 0` is consumed and discarded.
  - An accepted LU result that did not bypass is pushed at the tail.
  - Pushing and popping in the same cycle is legal; count stays unchanged.
- **Drain order:** FIFO order. Entries are never reordered or merged.
- **Starvation counter, updated at the clock edge:**
  - Cleared when a pop occurs.
  - Also cleared when count was 0 at cycle start.
  - Otherwise increments, saturating at STARVE_MAX.
- **`pend_rd_mask`:** computed from registered FIFO contents. It reflects entries present at cycle start, not a push in the current cycle.
- **WAW hazards:** the decode scoreboard must not issue a younger writer to a register set in `pend_rd_mask` or in-flight to the LU. The arbiter does not check for this.
- **Reset (`rst_n` low at a clock edge):**
  - count, pointers and `starve` are cleared.
  - While `rst_n` is low, outputs are forced to: `rf_wen = 0`, `lu_ready = 0`, `wb_stall = 0`, `pend_rd_mask = 0`, `lu_count = 0`.
  - Reset mid-operation discards all buffered entries.

## Timing
- WB → register file: 0 cycles (combinational pass-through). LU → register file: 0 cycles via bypass; otherwise ≥1.
- An entry pushed in cycle T, with WB writing every cycle, drains no later than cycle T+STARVE_MAX+1. Later entries wait at most STARVE_MAX+1 cycles after the previous pop.
- `wb_stall` lasts exactly one cycle per forced drain. It is deasserted the next cycle because `starve` clears on the pop.
- `lu_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.

## Test plan
1. **Reset:** hold `rst_n = 0` for 3 cycles with `lu_valid = 1` and `ws_reg_wen = 1`, `ws_rd = 4` → `rf_wen = 0`, `lu_ready = 0`, `wb_stall = 0`. After release, `lu_count = 0` and `lu_ready = 1`.
2. **Bypass:** WB idle; LU `rd = 5`, data `0xDEADBEEF`, for one cycle → same cycle `rf_wen = 1`, `rf_waddr = 5`, `rf_wdata = 0xDEADBEEF`. `lu_count` stays 0.
3. **Starvation:** WB writes `rd = 3`, data `0x11`, every cycle; LU pushes `rd = 7`, data `0x22`, in cycle T.
   - `pend_rd_mask = 0x80` from T+1.
   - `wb_stall = 1` in T+5 (STARVE_MAX = 4), with `rf_waddr = 7`, `rf_wdata = 0x22`.
   - In T+6, `wb_stall = 0` and WB writes `rd = 3` again.
4. **Full/backpressure:** WB writes every cycle; LU pushes `rd = 8`, then `rd = 9`, back-to-back.
   - `lu_ready = 0` from the third cycle while `lu_valid` is held with `rd = 10`.
   - Drains occur in order 8, 9 via stall cycles.
   - `rd = 10` is accepted the cycle after the first pop.
5. **x0 handling:**
   - LU `rd = 0` accepted → no write, `lu_count` unchanged.
   - With one entry buffered, WB `ws_reg_wen = 1`, `ws_rd = 0` → the head drains that cycle and `starve` clears.
6. **Reset mid-operation:** two entries buffered, `rst_n` pulsed low for 1 cycle → `lu_count = 0`, `pend_rd_mask = 0`. No buffered entry is ever written afterwards.
